// File: rtl/uart_rx_monitor_if.sv
// uart_rx_monitor_if: valid/ready drain port carrying the head-of-FIFO character and its error flags
interface uart_rx_monitor_if #(parameter int DATA_BITS = 8);
   logic [DATA_BITS-1:0] data_o;
   logic frame_err_o, parity_err_o, valid_o, ready_i;
   modport master(output data_o, frame_err_o, parity_err_o, valid_o, input ready_i);
   modport slave(input data_o, frame_err_o, parity_err_o, valid_o, output ready_i);
endinterface

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: UART receiver with framing/parity checks and a FWFT character FIFO; UART_RX_MONITOR_DISPLAY_EN adds simulation printing
module uart_rx_monitor #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS = 8,
   parameter int PARITY = 0,
   parameter int STOP_BITS = 1,
   parameter int FIFO_AW = 3
)(
   input logic clk,
   input logic rst,
   input logic rx_i,
   input logic clear_i,
   uart_rx_monitor_if.master drain,
   output logic [FIFO_AW:0] count_o,
   output logic overflow_o,
   output logic busy_o
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int EW = DATA_BITS + 2;
   localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PAR = 3'd3, STOP = 3'd4, BRK = 3'd5;
   localparam logic [CW-1:0] FULL_RL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_RL = CW'(CLKS_PER_BIT / 2 - 1);
   logic s1, s2, hist, fall, tick, push, pop, full, do_push;
   logic [2:0] state, bidx;
   logic [CW-1:0] cnt;
   logic [DATA_BITS-1:0] sr;
   logic pe, fe;
   logic [EW-1:0] entry;
   logic [EW-1:0] mem [DEPTH];
   logic [FIFO_AW-1:0] wp, rp;
   assign fall = hist & ~s2;
   assign tick = cnt == '0;
   assign push = state == STOP && tick && bidx == 3'(STOP_BITS - 1);
   assign entry = {pe, fe | ~s2, sr};
   assign full = count_o == (FIFO_AW+1)'(DEPTH);
   assign pop = drain.valid_o & drain.ready_i;
   assign do_push = push & (~full | pop) & ~clear_i;
   assign busy_o = state != IDLE;
   assign drain.valid_o = count_o != '0;
   assign {drain.parity_err_o, drain.frame_err_o, drain.data_o} = drain.valid_o ? mem[rp] : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {s1, s2, hist} <= 3'b111;
         state <= IDLE;
         bidx <= '0;
         cnt <= '0;
         sr <= '0;
         pe <= 1'b0;
         fe <= 1'b0;
      end else begin
         s1 <= rx_i;
         s2 <= s1;
         hist <= s2;
         if (!tick) cnt <= cnt - 1'b1;
         case (state)
            IDLE: if (fall) begin
               cnt <= HALF_RL;
               state <= START;
            end
            START: if (tick) begin
               cnt <= FULL_RL;
               bidx <= '0;
               state <= s2 ? IDLE : DATA;
            end
            DATA: if (tick) begin
               sr <= {s2, sr[DATA_BITS-1:1]};
               cnt <= FULL_RL;
               bidx <= bidx + 1'b1;
               pe <= 1'b0;
               fe <= 1'b0;
               if (bidx == 3'(DATA_BITS - 1)) begin
                  bidx <= '0;
                  state <= PARITY != 0 ? PAR : STOP;
               end
            end
            PAR: if (tick) begin
               pe <= (^sr ^ s2) != (PARITY == 1);
               cnt <= FULL_RL;
               state <= STOP;
            end
            STOP: if (tick) begin
               fe <= fe | ~s2;
               cnt <= FULL_RL;
               bidx <= bidx + 1'b1;
               if (bidx == 3'(STOP_BITS - 1)) state <= s2 ? IDLE : BRK;
            end
            BRK: if (s2) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count_o <= '0;
         overflow_o <= 1'b0;
      end else if (clear_i) begin
         wp <= '0;
         rp <= '0;
         count_o <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         count_o <= count_o + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(pop);
         if (push & full & ~pop) overflow_o <= 1'b1;
      end
   end
   always_ff @(posedge clk) if (do_push) mem[wp] <= entry;
`ifdef UART_RX_MONITOR_DISPLAY_EN
   always @(posedge clk) begin
      if (!rst && push && !clear_i) begin
         if (do_push) $write("%c", sr);
         if (do_push && (pe | fe | ~s2)) $display("[uart_rx_monitor] frame/parity error at %0t", $time);
         if (!do_push) $display("[uart_rx_monitor] overflow");
      end
   end
`endif
endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: drives two receiver configurations (8N1, and 7 data bits with even parity and 2 stop bits) against a queue model
module tb_uart_rx_monitor;
   localparam int CPB = 16;
   logic clk = 0, rst = 1, rx0 = 1, rx1 = 1, clr0 = 0, clr1 = 0;
   logic [3:0] cnt0, cnt1;
   logic ovf0, ovf1, busy0, busy1;
   int total = 0, bad = 0, cyc = 0, first_v0 = -1, start_cyc = 0;
   logic [9:0] q0[$], q1[$];
   uart_rx_monitor_if #(.DATA_BITS(8)) b0();
   uart_rx_monitor_if #(.DATA_BITS(7)) b1();
   uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_AW(3)) u0 (
      .clk(clk), .rst(rst), .rx_i(rx0), .clear_i(clr0), .drain(b0),
      .count_o(cnt0), .overflow_o(ovf0), .busy_o(busy0));
   uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_AW(3)) u1 (
      .clk(clk), .rst(rst), .rx_i(rx1), .clear_i(clr1), .drain(b1),
      .count_o(cnt1), .overflow_o(ovf1), .busy_o(busy1));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // Entries are {parity_err, frame_err, data}; 10'h3ff can never be produced by either instance
   always @(negedge clk) begin
      if (b0.valid_o && b0.ready_i) begin
         if (first_v0 < 0) first_v0 = cyc;
         chk("u0_entry", {b0.parity_err_o, b0.frame_err_o, b0.data_o}, q0.size() != 0 ? q0.pop_front() : 10'h3ff);
      end
      if (b1.valid_o && b1.ready_i)
         chk("u1_entry", {b1.parity_err_o, b1.frame_err_o, 1'b0, b1.data_o}, q1.size() != 0 ? q1.pop_front() : 10'h3ff);
   end
   task automatic drive(input bit w, input logic v, input int cycles);
      if (w) rx1 = v;
      else rx0 = v;
      repeat (cycles) @(negedge clk);
   endtask
   task automatic send0(input logic [7:0] d, input logic stopb, input bit model);
      if (model) q0.push_back({1'b0, ~stopb, d});
      drive(0, 0, CPB);
      for (int i = 0; i < 8; i++) drive(0, d[i], CPB);
      drive(0, stopb, CPB);
      drive(0, 1, CPB);
   endtask
   task automatic send1(input logic [6:0] d, input logic pb, input logic [1:0] st);
      q1.push_back({(($countones(d) + int'(pb)) % 2) != 0, ~(st[0] & st[1]), 1'b0, d});
      drive(1, 0, CPB);
      for (int i = 0; i < 7; i++) drive(1, d[i], CPB);
      drive(1, pb, CPB);
      drive(1, st[0], CPB);
      drive(1, st[1], CPB);
      drive(1, 1, CPB);
   endtask
   task automatic wait_drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || cnt0 != 0 || cnt1 != 0) && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue", q0.size() + q1.size(), 0);
      chk("drain_count", {cnt0, cnt1}, 0);
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
   initial begin
      b0.ready_i = 1;
      b1.ready_i = 1;
      repeat (3) @(negedge clk);
      chk("rst_head", {b0.valid_o, b0.frame_err_o, b0.parity_err_o, b0.data_o}, 0);
      chk("rst_status", {cnt0, ovf0, busy0}, 0);
      chk("rst_u1", {b1.valid_o, cnt1, ovf1, busy1}, 0);
      rst = 0;
      repeat (2) @(negedge clk);
      start_cyc = cyc;
      first_v0 = -1;
      send0(8'h55, 1, 1);
      wait_drain();
      chk("latency_window", (first_v0 - start_cyc >= 137) && (first_v0 - start_cyc <= 160), 1);
      send1(7'h41, 1, 2'b11);
      send1(7'h41, 0, 2'b11);
      wait_drain();
      b0.ready_i = 0;
      q0.push_back({2'b01, 8'ha3});
      drive(0, 0, CPB);
      for (int i = 0; i < 8; i++) drive(0, 1'((8'ha3 >> i) & 1), CPB);
      drive(0, 0, 41 * CPB);
      chk("break_busy", busy0, 1);
      chk("break_count", cnt0, 1);
      rx0 = 1;
      repeat (8) @(negedge clk);
      chk("break_idle", busy0, 0);
      chk("break_single", cnt0, 1);
      b0.ready_i = 1;
      wait_drain();
      drive(0, 0, 4);
      drive(0, 1, 3);
      chk("glitch_busy", busy0, 1);
      drive(0, 1, 30);
      chk("glitch_idle", busy0, 0);
      chk("glitch_count", cnt0, 0);
      b0.ready_i = 0;
      for (int i = 0; i < 9; i++) send0(8'(i), 1, i < 8);
      chk("ovf_count", cnt0, 8);
      chk("ovf_flag", ovf0, 1);
      b0.ready_i = 1;
      wait_drain();
      chk("ovf_sticky", ovf0, 1);
      clr0 = 1;
      @(negedge clk);
      clr0 = 0;
      chk("ovf_clear", ovf0, 0);
      drive(0, 0, CPB);
      for (int i = 0; i < 3; i++) drive(0, 1, CPB);
      drive(0, 1, CPB / 2);
      rst = 1;
      @(negedge clk);
      chk("midrst_status", {cnt0, ovf0, busy0, b0.valid_o}, 0);
      chk("midrst_head", {b0.frame_err_o, b0.parity_err_o, b0.data_o}, 0);
      repeat (3) @(negedge clk);
      rst = 0;
      drive(0, 1, 2 * CPB);
      send0(8'h12, 1, 1);
      wait_drain();
      for (int k = 0; k < 16; k++) begin
         logic [7:0] d;
         logic [1:0] st;
         d = 8'($urandom);
         st = ($urandom % 8) == 0 ? 2'($urandom) : 2'b11;
         send0(d, ($urandom % 8) != 0, 1);
         send1(d[6:0], 1'($urandom), st);
      end
      wait_drain();
      chk("final_ovf", {ovf0, ovf1}, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
